ddr_cmd_scheduler: RTL and testbench

Sequences read/write requests from the controller front end into legal DDR4 command streams (PRE/ACT/RD/WR/REF) with open-page bank tracking and periodic refresh. Emits exactly one `command_type` per clock, defaulting to NOP, which the controller then hands to the DDR interface command-pin driver. Only one request is in flight at a time; ordering is strictly preserved.

---
 rtl/ddr_cmd_scheduler_pkg.sv | 56 +++++
 rtl/ddr_cmd_scheduler_bank.sv | 78 +++++++
 rtl/ddr_cmd_scheduler.sv | 222 ++++++++++++++++++++++
 tb/tb_ddr_cmd_scheduler.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ddr_cmd_scheduler_pkg.sv
// ddr_cmd_scheduler_pkg
//   Shared DDR definitions: address widths, the command encoding, the
//   command_type bundle driven onto the command pins, and the scheduler
//   FSM state codes.
package ddr_cmd_scheduler_pkg;

  localparam int BG_WIDTH  = 2;
  localparam int BA_WIDTH  = 2;
  localparam int ROW_WIDTH = 14;
  localparam int COL_WIDTH = 10;
  localparam int BANK_W    = BG_WIDTH + BA_WIDTH;
  localparam int NUM_BANKS = 1 << BANK_W;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_PRE  = 3'd2,
    CMD_PREA = 3'd3,
    CMD_RD   = 3'd4,
    CMD_WR   = 3'd5,
    CMD_REF  = 3'd6
  } cmd_e;

  typedef struct packed {
    cmd_e                 cmd;
    logic [BG_WIDTH-1:0]  bg_addr;
    logic [BA_WIDTH-1:0]  ba_addr;
    logic [ROW_WIDTH-1:0] row_addr;
    logic [COL_WIDTH-1:0] col_addr;
  } command_type;

  // Scheduler FSM state codes
  localparam logic [3:0] ST_IDLE         = 4'd0;
  localparam logic [3:0] ST_DECODE       = 4'd1;
  localparam logic [3:0] ST_PRE          = 4'd2;
  localparam logic [3:0] ST_WAIT_RP      = 4'd3;
  localparam logic [3:0] ST_ACT          = 4'd4;
  localparam logic [3:0] ST_WAIT_RCD     = 4'd5;
  localparam logic [3:0] ST_CAS          = 4'd6;
  localparam logic [3:0] ST_REF_PREA     = 4'd7;
  localparam logic [3:0] ST_REF_WAIT_RP  = 4'd8;
  localparam logic [3:0] ST_REF          = 4'd9;
  localparam logic [3:0] ST_REF_WAIT_RFC = 4'd10;

  // NOP with every address pin parked high, matching idle pin levels.
  function automatic command_type nop_cmd();
    command_type c;
    c.cmd      = CMD_NOP;
    c.bg_addr  = '1;
    c.ba_addr  = '1;
    c.row_addr = '1;
    c.col_addr = '1;
    return c;
  endfunction

endpackage

// File: rtl/ddr_cmd_scheduler_bank.sv
// ddr_bank_tracker
//   Per-bank open flag, open row and tRAS down-counter.
//   Ports:
//     i_clk, i_reset_n        clock, synchronous active-low reset
//     i_lookup_idx            bank to inspect; o_lookup_* are combinational
//     i_act/i_upd_idx/i_act_row  open a row (loads tRAS counter)
//     i_pre                   close bank i_upd_idx
//     i_prea                  close every bank
//     o_all_ras_done          every tRAS counter is zero
//     o_any_open              at least one bank is open
module ddr_bank_tracker
  import ddr_cmd_scheduler_pkg::*;
#(
  parameter int T_RAS = 28
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [BANK_W-1:0]    i_lookup_idx,
  output logic                 o_lookup_open,
  output logic [ROW_WIDTH-1:0] o_lookup_row,
  output logic                 o_lookup_ras_done,
  input  logic                 i_act,
  input  logic [BANK_W-1:0]    i_upd_idx,
  input  logic [ROW_WIDTH-1:0] i_act_row,
  input  logic                 i_pre,
  input  logic                 i_prea,
  output logic                 o_all_ras_done,
  output logic                 o_any_open
);

  localparam int RAS_W = $clog2(T_RAS + 1);
  localparam logic [RAS_W-1:0] RAS_LOAD = RAS_W'(T_RAS - 1);

  logic [NUM_BANKS-1:0] w_open_vec;
  logic [NUM_BANKS-1:0] w_ras_zero;
  logic [ROW_WIDTH-1:0] w_row_arr [NUM_BANKS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic             r_open;
      logic [ROW_WIDTH-1:0] r_row;
      logic [RAS_W-1:0] r_ras;
      logic             w_sel;

      assign w_sel = (i_upd_idx == BANK_W'(gi));

      always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
          r_open <= 1'b0;
          r_ras  <= '0;
        end else if (i_act && w_sel) begin
          r_open <= 1'b1;
          r_ras  <= RAS_LOAD;
        end else begin
          if (r_ras != '0) r_ras <= r_ras - 1'b1;
          if (i_prea || (i_pre && w_sel)) r_open <= 1'b0;
        end
      end

      // Row contents are only meaningful while r_open is set, so no reset.
      always_ff @(posedge i_clk) begin
        if (i_act && w_sel) r_row <= i_act_row;
      end

      assign w_open_vec[gi] = r_open;
      assign w_ras_zero[gi] = (r_ras == '0);
      assign w_row_arr[gi]  = r_row;
    end
  endgenerate

  assign o_lookup_open     = w_open_vec[i_lookup_idx];
  assign o_lookup_row      = w_row_arr[i_lookup_idx];
  assign o_lookup_ras_done = w_ras_zero[i_lookup_idx];
  assign o_all_ras_done    = &w_ras_zero;
  assign o_any_open        = |w_open_vec;

endmodule

// File: rtl/ddr_cmd_scheduler.sv
// ddr_cmd_scheduler
//   Turns one read/write request at a time into a legal DDR4 command stream
//   (PRE/ACT/RD/WR) with open-page tracking, and interleaves periodic
//   refresh (PREA/REF). One registered command per clock, NOP otherwise.
//   Ports:
//     i_clock_n, i_reset_n    clock (posedge), synchronous active-low reset
//     i_req_*/o_req_ready     request handshake and fields
//     o_cmd_out               registered command bundle
//     o_rd_issue, o_wr_issue  pulse with an RD / WR on o_cmd_out
//     o_ref_busy              refresh sequence in progress
module ddr_cmd_scheduler
  import ddr_cmd_scheduler_pkg::*;
#(
  parameter int T_RCD  = 11,
  parameter int T_RP   = 11,
  parameter int T_RAS  = 28,
  parameter int T_RFC  = 208,
  parameter int T_REFI = 7800
) (
  input  logic                 i_clock_n,
  input  logic                 i_reset_n,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_write,
  input  logic [BG_WIDTH-1:0]  i_req_bg,
  input  logic [BA_WIDTH-1:0]  i_req_ba,
  input  logic [ROW_WIDTH-1:0] i_req_row,
  input  logic [COL_WIDTH-1:0] i_req_col,
  output command_type          o_cmd_out,
  output logic                 o_rd_issue,
  output logic                 o_wr_issue,
  output logic                 o_ref_busy
);

  localparam int T_MAX  = (T_RFC > T_RAS) ? ((T_RFC > T_RCD) ? ((T_RFC > T_RP) ? T_RFC : T_RP)
                                                             : ((T_RCD > T_RP) ? T_RCD : T_RP))
                                          : ((T_RAS > T_RCD) ? ((T_RAS > T_RP) ? T_RAS : T_RP)
                                                             : ((T_RCD > T_RP) ? T_RCD : T_RP));
  localparam int CNT_W  = $clog2(T_MAX + 1);
  localparam int REFI_W = $clog2(T_REFI + 1);

  // A wait state spanning T-1 cycles is loaded with T-2 and exits at zero;
  // for T == 1 the wait state is skipped entirely.
  localparam logic [CNT_W-1:0] RCD_LOAD = CNT_W'(T_RCD - 2);
  localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(T_RP - 2);
  localparam logic [CNT_W-1:0] RFC_LOAD = CNT_W'(T_RFC - 2);

  logic [3:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  command_type          r_cmd;
  logic                 r_rd_issue, r_wr_issue, r_ready, r_ref_busy;
  logic                 r_ref_pending;
  logic [REFI_W-1:0]    r_refi_cnt;
  logic                 r_req_write;
  logic [BG_WIDTH-1:0]  r_req_bg;
  logic [BA_WIDTH-1:0]  r_req_ba;
  logic [ROW_WIDTH-1:0] r_req_row;
  logic [COL_WIDTH-1:0] r_req_col;

  logic [3:0]           w_state_next;
  logic [CNT_W-1:0]     w_cnt_next;
  command_type          w_cmd_next;
  logic                 w_rd_next, w_wr_next, w_accept;
  logic                 w_act, w_pre, w_prea, w_ref_issue;
  logic                 w_refi_wrap, w_pending_next;
  logic [BANK_W-1:0]    w_req_idx;
  logic                 w_bank_open, w_bank_ras_done, w_all_ras_done, w_any_open;
  logic [ROW_WIDTH-1:0] w_bank_row;

  assign w_req_idx = {r_req_bg, r_req_ba};

  ddr_bank_tracker #(.T_RAS(T_RAS)) u_bank_tracker (
    .i_clk             (i_clock_n),
    .i_reset_n         (i_reset_n),
    .i_lookup_idx      (w_req_idx),
    .o_lookup_open     (w_bank_open),
    .o_lookup_row      (w_bank_row),
    .o_lookup_ras_done (w_bank_ras_done),
    .i_act             (w_act),
    .i_upd_idx         (w_req_idx),
    .i_act_row         (r_req_row),
    .i_pre             (w_pre),
    .i_prea            (w_prea),
    .o_all_ras_done    (w_all_ras_done),
    .o_any_open        (w_any_open)
  );

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_cmd_next   = nop_cmd();
    w_rd_next    = 1'b0;
    w_wr_next    = 1'b0;
    w_accept     = 1'b0;
    w_act        = 1'b0;
    w_pre        = 1'b0;
    w_prea       = 1'b0;
    w_ref_issue  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_ref_pending) begin
          w_state_next = w_any_open ? ST_REF_PREA : ST_REF;
        end else if (i_req_valid && r_ready) begin
          w_accept     = 1'b1;
          w_state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!w_bank_open)                 w_state_next = ST_ACT;
        else if (w_bank_row == r_req_row) w_state_next = ST_CAS;
        else                              w_state_next = ST_PRE;
      end
      ST_PRE: begin
        if (w_bank_ras_done) begin
          w_cmd_next.cmd     = CMD_PRE;
          w_cmd_next.bg_addr = r_req_bg;
          w_cmd_next.ba_addr = r_req_ba;
          w_pre              = 1'b1;
          w_cnt_next         = RP_LOAD;
          w_state_next       = (T_RP > 1) ? ST_WAIT_RP : ST_ACT;
        end
      end
      ST_WAIT_RP: begin
        if (r_cnt == '0) w_state_next = ST_ACT;
        else             w_cnt_next   = r_cnt - 1'b1;
      end
      ST_ACT: begin
        w_cmd_next.cmd      = CMD_ACT;
        w_cmd_next.bg_addr  = r_req_bg;
        w_cmd_next.ba_addr  = r_req_ba;
        w_cmd_next.row_addr = r_req_row;
        w_act               = 1'b1;
        w_cnt_next          = RCD_LOAD;
        w_state_next        = (T_RCD > 1) ? ST_WAIT_RCD : ST_CAS;
      end
      ST_WAIT_RCD: begin
        if (r_cnt == '0) w_state_next = ST_CAS;
        else             w_cnt_next   = r_cnt - 1'b1;
      end
      ST_CAS: begin
        w_cmd_next.cmd      = r_req_write ? CMD_WR : CMD_RD;
        w_cmd_next.bg_addr  = r_req_bg;
        w_cmd_next.ba_addr  = r_req_ba;
        w_cmd_next.col_addr = r_req_col;
        w_rd_next           = !r_req_write;
        w_wr_next           = r_req_write;
        w_state_next        = ST_IDLE;
      end
      ST_REF_PREA: begin
        if (w_all_ras_done) begin
          w_cmd_next.cmd = CMD_PREA;
          w_prea         = 1'b1;
          w_cnt_next     = RP_LOAD;
          w_state_next   = (T_RP > 1) ? ST_REF_WAIT_RP : ST_REF;
        end
      end
      ST_REF_WAIT_RP: begin
        if (r_cnt == '0) w_state_next = ST_REF;
        else             w_cnt_next   = r_cnt - 1'b1;
      end
      ST_REF: begin
        w_cmd_next.cmd = CMD_REF;
        w_ref_issue    = 1'b1;
        w_cnt_next     = RFC_LOAD;
        w_state_next   = (T_RFC > 1) ? ST_REF_WAIT_RFC : ST_IDLE;
      end
      ST_REF_WAIT_RFC: begin
        if (r_cnt == '0) w_state_next = ST_IDLE;
        else             w_cnt_next   = r_cnt - 1'b1;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // A wrap that coincides with REF starts a fresh interval, so it wins.
  assign w_refi_wrap    = (r_refi_cnt == REFI_W'(T_REFI - 1));
  assign w_pending_next = w_refi_wrap | (r_ref_pending & ~w_ref_issue);

  always_ff @(posedge i_clock_n) begin
    if (!i_reset_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_cmd         <= nop_cmd();
      r_rd_issue    <= 1'b0;
      r_wr_issue    <= 1'b0;
      r_ready       <= 1'b0;
      r_ref_busy    <= 1'b0;
      r_ref_pending <= 1'b0;
      r_refi_cnt    <= '0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_cmd         <= w_cmd_next;
      r_rd_issue    <= w_rd_next;
      r_wr_issue    <= w_wr_next;
      // Ready is registered from the next state so a pending refresh
      // blocks acceptance in the same cycle it becomes visible.
      r_ready       <= (w_state_next == ST_IDLE) && !w_pending_next;
      r_ref_busy    <= (w_state_next == ST_REF_PREA) || (w_state_next == ST_REF_WAIT_RP) ||
                       (w_state_next == ST_REF)      || (w_state_next == ST_REF_WAIT_RFC);
      r_ref_pending <= w_pending_next;
      r_refi_cnt    <= w_refi_wrap ? '0 : r_refi_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clock_n) begin
    if (w_accept) begin
      r_req_write <= i_req_write;
      r_req_bg    <= i_req_bg;
      r_req_ba    <= i_req_ba;
      r_req_row   <= i_req_row;
      r_req_col   <= i_req_col;
    end
  end

  assign o_req_ready = r_ready;
  assign o_cmd_out   = r_cmd;
  assign o_rd_issue  = r_rd_issue;
  assign o_wr_issue  = r_wr_issue;
  assign o_ref_busy  = r_ref_busy;

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// tb_ddr_cmd_scheduler
//   Directed bench: a table of requests with hand-computed command offsets,
//   plus hand-written reset, refresh and mid-sequence reset sequences.
module tb_ddr_cmd_scheduler;
  import ddr_cmd_scheduler_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [BG_WIDTH-1:0]  req_bg;
  logic [BA_WIDTH-1:0]  req_ba;
  logic [ROW_WIDTH-1:0] req_row;
  logic [COL_WIDTH-1:0] req_col;
  command_type          cmd_out;
  logic                 rd_issue, wr_issue, ref_busy;

  int total = 0;
  int bad   = 0;
  int n_edges = 0;

  always #5 clk = ~clk;

  // Count edges the DUT sees out of reset (refresh timer reference).
  always @(posedge clk) begin
    if (!reset_n) n_edges = 0;
    else          n_edges = n_edges + 1;
  end

  ddr_cmd_scheduler #(
    .T_RCD(3), .T_RP(3), .T_RAS(6), .T_RFC(10), .T_REFI(200)
  ) dut (
    .i_clock_n  (clk),
    .i_reset_n  (reset_n),
    .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .i_req_write(req_write),
    .i_req_bg   (req_bg),
    .i_req_ba   (req_ba),
    .i_req_row  (req_row),
    .i_req_col  (req_col),
    .o_cmd_out  (cmd_out),
    .o_rd_issue (rd_issue),
    .o_wr_issue (wr_issue),
    .o_ref_busy (ref_busy)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [13:0] row;
    logic [9:0]  col;
    int          pre_at;   // edge offset from acceptance, -1 = none
    int          act_at;
    int          cas_at;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic chk_cmd(input string tag, input cmd_e ec, input logic [1:0] ebg,
                         input logic [1:0] eba, input logic [13:0] erow, input logic [9:0] ecol);
    chk($sformatf("%s.cmd", tag), 32'(cmd_out.cmd), 32'(ec));
    if (ec == CMD_NOP)
      chk($sformatf("%s.nop_addr", tag),
          32'({cmd_out.bg_addr, cmd_out.ba_addr, cmd_out.row_addr, cmd_out.col_addr}), 32'h0FFF_FFFF);
    if (ec == CMD_ACT || ec == CMD_PRE || ec == CMD_RD || ec == CMD_WR) begin
      chk($sformatf("%s.bg", tag), 32'(cmd_out.bg_addr), 32'(ebg));
      chk($sformatf("%s.ba", tag), 32'(cmd_out.ba_addr), 32'(eba));
    end
    if (ec == CMD_ACT) chk($sformatf("%s.row", tag), 32'(cmd_out.row_addr), 32'(erow));
    if (ec == CMD_RD || ec == CMD_WR) chk($sformatf("%s.col", tag), 32'(cmd_out.col_addr), 32'(ecol));
    chk($sformatf("%s.rd_issue", tag), 32'(rd_issue), 32'(ec == CMD_RD));
    chk($sformatf("%s.wr_issue", tag), 32'(wr_issue), 32'(ec == CMD_WR));
  endtask

  // Called at a negedge; returns at the negedge after the CAS edge.
  task automatic run_vec(input vec_t v, input int idx);
    int   waited;
    cmd_e ec;
    req_write = v.wr; req_bg = v.bg; req_ba = v.ba; req_row = v.row; req_col = v.col;
    req_valid = 1'b1;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk($sformatf("v%0d.ready_wait", idx), 32'(req_ready), 32'd1);
    if (req_ready !== 1'b1) begin
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk($sformatf("v%0d.ready_drop", idx), 32'(req_ready), 32'd0);
    for (int k = 1; k <= v.cas_at; k++) begin
      @(negedge clk);
      ec = CMD_NOP;
      if (k == v.pre_at) ec = CMD_PRE;
      if (k == v.act_at) ec = CMD_ACT;
      if (k == v.cas_at) ec = v.wr ? CMD_WR : CMD_RD;
      chk_cmd($sformatf("v%0d.e%0d", idx, k), ec, v.bg, v.ba, v.row, v.col);
      chk($sformatf("v%0d.e%0d.ready", idx, k), 32'(req_ready), 32'(k == v.cas_at));
    end
    $display("txn %0d: %s bg=%0d ba=%0d row=%h col=%h done", idx, v.wr ? "WR" : "RD",
             v.bg, v.ba, v.row, v.col);
  endtask

  initial begin
    cmd_e ec;
    int   guard;
    vec_t vr;

    vecs[0] = '{1'b0, 2'd1, 2'd2, 14'h0155, 10'h03A, -1, 2, 5};  // empty bank
    vecs[1] = '{1'b1, 2'd1, 2'd2, 14'h0155, 10'h011, -1, -1, 2}; // page hit
    vecs[2] = '{1'b0, 2'd0, 2'd1, 14'h0155, 10'h007, -1, 2, 5};  // empty bank
    vecs[3] = '{1'b0, 2'd0, 2'd1, 14'h0200, 10'h03F, 2, 5, 8};   // miss right after ACT
    vecs[4] = '{1'b0, 2'd3, 2'd3, 14'h3FFF, 10'h3FF, -1, 2, 5};  // all-ones address
    vecs[5] = '{1'b1, 2'd3, 2'd3, 14'h0000, 10'h000, 2, 5, 8};   // miss, zero address
    vecs[6] = '{1'b0, 2'd1, 2'd2, 14'h0155, 10'h022, -1, -1, 2}; // hit survives others

    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_bg = '0; req_ba = '0; req_row = '0; req_col = '0;

    // Reset held for three edges
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_cmd($sformatf("rst%0d", i), CMD_NOP, 2'd0, 2'd0, 14'd0, 10'd0);
      chk($sformatf("rst%0d.ready", i), 32'(req_ready), 32'd0);
      chk($sformatf("rst%0d.busy", i), 32'(ref_busy), 32'd0);
    end
    reset_n = 1'b1;
    chk("rel.ready_before_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("rel.ready", 32'(req_ready), 32'd1);
    chk_cmd("rel", CMD_NOP, 2'd0, 2'd0, 14'd0, 10'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Refresh: timer wraps on the 200th edge out of reset
    guard = 0;
    while (n_edges < 199 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    chk("ref.edge_sync", 32'(n_edges), 32'd199);
    chk("ref.ready_pre_wrap", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("ref.ready_at_wrap", 32'(req_ready), 32'd0);
    req_write = 1'b0; req_bg = 2'd1; req_ba = 2'd2; req_row = 14'h0155; req_col = 10'h001;
    req_valid = 1'b1;
    for (int e = 201; e <= 220; e++) begin
      @(negedge clk);
      ec = CMD_NOP;
      if (e == 202) ec = CMD_PREA;
      if (e == 205) ec = CMD_REF;
      if (e == 217) ec = CMD_ACT;
      if (e == 220) ec = CMD_RD;
      chk_cmd($sformatf("ref.e%0d", e), ec, 2'd1, 2'd2, 14'h0155, 10'h001);
      chk($sformatf("ref.e%0d.busy", e), 32'(ref_busy), 32'(e <= 213));
      chk($sformatf("ref.e%0d.ready", e), 32'(req_ready), 32'(e == 214 || e == 220));
      if (e == 215) req_valid = 1'b0;
    end
    $display("txn ref: refresh then RD bg=1 ba=2 row=0155 col=001 done");

    // Reset during WAIT_RCD
    req_write = 1'b0; req_bg = 2'd2; req_ba = 2'd3; req_row = 14'h00AB; req_col = 10'h005;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid.accepted", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk_cmd("mid.decode", CMD_NOP, 2'd0, 2'd0, 14'd0, 10'd0);
    @(negedge clk);
    chk_cmd("mid.act", CMD_ACT, 2'd2, 2'd3, 14'h00AB, 10'h005);
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_cmd($sformatf("mid.rst%0d", i), CMD_NOP, 2'd0, 2'd0, 14'd0, 10'd0);
      chk($sformatf("mid.rst%0d.ready", i), 32'(req_ready), 32'd0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_cmd($sformatf("mid.post%0d", i), CMD_NOP, 2'd0, 2'd0, 14'd0, 10'd0);
    end
    $display("txn mid: request abandoned by reset");
    vr = '{1'b0, 2'd2, 2'd3, 14'h00AB, 10'h005, -1, 2, 5};
    run_vec(vr, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
